// File: rtl/dcache_miss_ctrl.sv
// ---------------------------------------------------------------------------
// dcache_miss_ctrl
//   Memory-side controller for a direct-mapped data cache: 8 sets, 2 words
//   per block, 26-bit tag, byte address = {tag, indx, offset, 2'b00}.
//
//   A miss writes back the dirty victim block (if any) and then fetches the
//   requested two-word block. Each fetched word is handed to the cache one
//   cycle later on fill_we. On halt, all sets are walked in order, every
//   dirty block is written back, and flushed is then raised.
//
//   Ports
//     CLK, nRST            clock, synchronous active-low reset
//     req, req_tag/indx    miss request (held until done) and missing address
//     vic_*                victim block of the set on req_indx (miss) or on
//                          fill_indx (flush), driven by the cache
//     halt                 start the flush walk
//     hit_count            hit counter, written to memory at flush end
//                          (HITCOUNT_EN builds only)
//     dwait, dload         memory handshake / read data
//     dREN, dWEN, daddr,
//     dstore               memory request, held until a cycle with dwait=0
//     fill_*               fill-word write port into the cache
//     clr_dirty            pulse: clear dirty bit of set fill_indx
//     done                 pulse: miss serviced
//     flushed              flush complete, sticky until reset
//
//   Build option
//     HITCOUNT_EN  when defined, the end of the flush writes hit_count to
//                  HITCNT_ADDR before reaching the halted state.
//
//   All outputs are registers; each one is loaded on the edge that enters
//   the state it belongs to.
// ---------------------------------------------------------------------------
module dcache_miss_ctrl #(
    parameter int unsigned SETS        = 8,
    parameter logic [31:0] HITCNT_ADDR = 32'h0000_3100
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        req,
    input  logic [25:0] req_tag,
    input  logic [2:0]  req_indx,
    input  logic        vic_dirty,
    input  logic [25:0] vic_tag,
    input  logic [31:0] vic_word0,
    input  logic [31:0] vic_word1,
    input  logic        halt,
    input  logic [31:0] hit_count,
    input  logic        dwait,
    input  logic [31:0] dload,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    output logic        fill_we,
    output logic [2:0]  fill_indx,
    output logic        fill_offset,
    output logic [25:0] fill_tag,
    output logic [31:0] fill_data,
    output logic        clr_dirty,
    output logic        done,
    output logic        flushed
);

    typedef enum logic [3:0] {
        S_IDLE, S_WB0, S_WB1, S_RD0, S_RD1, S_DONE,
        S_FL_CHK, S_FL_WB0, S_FL_WB1, S_FL_NEXT, S_FL_END, S_HALTED
    } state_t;

    state_t      state_q;
    logic [2:0]  flush_idx_q;
    logic        dren_q, dwen_q, fill_we_q, fill_offset_q;
    logic        clr_dirty_q, done_q, flushed_q;
    logic [31:0] daddr_q, dstore_q, fill_data_q;
    logic [2:0]  fill_indx_q;
    logic [25:0] fill_tag_q;

    logic flush_last;
    assign flush_last = (flush_idx_q == 3'(SETS - 1));

`ifndef HITCOUNT_EN
    // hit_count and HITCNT_ADDR only matter when the hit-count write exists.
    logic unused_hitcount;
    assign unused_hitcount = ^{hit_count, HITCNT_ADDR};
`endif

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q       <= S_IDLE;
            flush_idx_q   <= '0;
            dren_q        <= 1'b0;
            dwen_q        <= 1'b0;
            daddr_q       <= '0;
            dstore_q      <= '0;
            fill_we_q     <= 1'b0;
            fill_indx_q   <= '0;
            fill_offset_q <= 1'b0;
            fill_tag_q    <= '0;
            fill_data_q   <= '0;
            clr_dirty_q   <= 1'b0;
            done_q        <= 1'b0;
            flushed_q     <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle.
            fill_we_q   <= 1'b0;
            clr_dirty_q <= 1'b0;
            done_q      <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        fill_indx_q <= req_indx;
                        fill_tag_q  <= req_tag;
                        if (vic_dirty) begin
                            state_q  <= S_WB0;
                            dwen_q   <= 1'b1;
                            daddr_q  <= {vic_tag, req_indx, 1'b0, 2'b00};
                            dstore_q <= vic_word0;
                        end else begin
                            state_q  <= S_RD0;
                            dren_q   <= 1'b1;
                            daddr_q  <= {req_tag, req_indx, 1'b0, 2'b00};
                        end
                    end else if (halt && !flushed_q) begin
                        state_q     <= S_FL_CHK;
                        fill_indx_q <= flush_idx_q;
                    end
                end

                // Second word of a writeback reuses the block address of the first.
                S_WB0, S_FL_WB0: begin
                    if (!dwait) begin
                        state_q  <= (state_q == S_WB0) ? S_WB1 : S_FL_WB1;
                        daddr_q  <= {daddr_q[31:3], 1'b1, 2'b00};
                        dstore_q <= vic_word1;
                    end
                end

                S_WB1: begin
                    if (!dwait) begin
                        state_q  <= S_RD0;
                        dwen_q   <= 1'b0;
                        dren_q   <= 1'b1;
                        daddr_q  <= {fill_tag_q, fill_indx_q, 1'b0, 2'b00};
                        dstore_q <= '0;
                    end
                end

                S_RD0: begin
                    if (!dwait) begin
                        state_q       <= S_RD1;
                        daddr_q       <= {daddr_q[31:3], 1'b1, 2'b00};
                        fill_we_q     <= 1'b1;
                        fill_offset_q <= 1'b0;
                        fill_data_q   <= dload;
                    end
                end

                // The last fill word lands in the same cycle as done.
                S_RD1: begin
                    if (!dwait) begin
                        state_q       <= S_DONE;
                        dren_q        <= 1'b0;
                        daddr_q       <= '0;
                        fill_we_q     <= 1'b1;
                        fill_offset_q <= 1'b1;
                        fill_data_q   <= dload;
                        done_q        <= 1'b1;
                        clr_dirty_q   <= 1'b1;
                    end
                end

                // A halt seen while the miss was running starts the flush
                // right away; req is not looked at here.
                S_DONE: begin
                    if (halt && !flushed_q) begin
                        state_q     <= S_FL_CHK;
                        fill_indx_q <= flush_idx_q;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end

                // Clean sets advance straight from FL_CHK; dirty sets come
                // back through FL_NEXT after their writeback.
                S_FL_CHK, S_FL_NEXT: begin
                    if (state_q == S_FL_CHK && vic_dirty) begin
                        state_q  <= S_FL_WB0;
                        dwen_q   <= 1'b1;
                        daddr_q  <= {vic_tag, flush_idx_q, 1'b0, 2'b00};
                        dstore_q <= vic_word0;
                    end else if (flush_last) begin
                        state_q <= S_FL_END;
`ifdef HITCOUNT_EN
                        dwen_q   <= 1'b1;
                        daddr_q  <= HITCNT_ADDR;
                        dstore_q <= hit_count;
`endif
                    end else begin
                        state_q     <= S_FL_CHK;
                        flush_idx_q <= flush_idx_q + 3'd1;
                        fill_indx_q <= flush_idx_q + 3'd1;
                    end
                end

                S_FL_WB1: begin
                    if (!dwait) begin
                        state_q     <= S_FL_NEXT;
                        dwen_q      <= 1'b0;
                        daddr_q     <= '0;
                        dstore_q    <= '0;
                        clr_dirty_q <= 1'b1;
                    end
                end

                S_FL_END: begin
`ifdef HITCOUNT_EN
                    if (!dwait) begin
                        state_q   <= S_HALTED;
                        dwen_q    <= 1'b0;
                        daddr_q   <= '0;
                        dstore_q  <= '0;
                        flushed_q <= 1'b1;
                    end
`else
                    state_q   <= S_HALTED;
                    flushed_q <= 1'b1;
`endif
                end

                S_HALTED: state_q <= S_HALTED;

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dREN        = dren_q;
    assign dWEN        = dwen_q;
    assign daddr       = daddr_q;
    assign dstore      = dstore_q;
    assign fill_we     = fill_we_q;
    assign fill_indx   = fill_indx_q;
    assign fill_offset = fill_offset_q;
    assign fill_tag    = fill_tag_q;
    assign fill_data   = fill_data_q;
    assign clr_dirty   = clr_dirty_q;
    assign done        = done_q;
    assign flushed     = flushed_q;

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dcache_miss_ctrl
//   Directed bench for dcache_miss_ctrl. Expected addresses are derived by
//   hand from {tag, indx, offset, 2'b00}. Inputs change 1 time unit after
//   the rising edge; outputs are checked at that same point.
// ---------------------------------------------------------------------------
module tb_dcache_miss_ctrl;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        req = 1'b0;
    logic [25:0] req_tag = '0;
    logic [2:0]  req_indx = '0;
    logic        vic_dirty = 1'b0;
    logic [25:0] vic_tag = '0;
    logic [31:0] vic_word0 = '0;
    logic [31:0] vic_word1 = '0;
    logic        halt = 1'b0;
    logic [31:0] hit_count = 32'h1234_5678;
    logic        dwait = 1'b0;
    logic [31:0] dload = '0;
    logic        dREN, dWEN, fill_we, fill_offset, clr_dirty, done, flushed;
    logic [31:0] daddr, dstore, fill_data;
    logic [2:0]  fill_indx;
    logic [25:0] fill_tag;

    always #5 CLK = ~CLK;

    dcache_miss_ctrl dut (
        .CLK(CLK), .nRST(nRST), .req(req), .req_tag(req_tag), .req_indx(req_indx),
        .vic_dirty(vic_dirty), .vic_tag(vic_tag), .vic_word0(vic_word0),
        .vic_word1(vic_word1), .halt(halt), .hit_count(hit_count),
        .dwait(dwait), .dload(dload), .dREN(dREN), .dWEN(dWEN), .daddr(daddr),
        .dstore(dstore), .fill_we(fill_we), .fill_indx(fill_indx),
        .fill_offset(fill_offset), .fill_tag(fill_tag), .fill_data(fill_data),
        .clr_dirty(clr_dirty), .done(done), .flushed(flushed)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_bus(input string tag, input logic ren, input logic wen,
                           input logic [31:0] addr, input logic [31:0] st);
        check({tag, " dREN"}, 32'(dREN), 32'(ren));
        check({tag, " dWEN"}, 32'(dWEN), 32'(wen));
        check({tag, " daddr"}, daddr, addr);
        check({tag, " dstore"}, dstore, st);
    endtask

    task automatic chk_zero(input string tag);
        chk_bus(tag, 1'b0, 1'b0, 32'h0, 32'h0);
        check({tag, " fill_we"}, 32'(fill_we), 32'h0);
        check({tag, " fill_indx"}, 32'(fill_indx), 32'h0);
        check({tag, " fill_offset"}, 32'(fill_offset), 32'h0);
        check({tag, " fill_tag"}, 32'(fill_tag), 32'h0);
        check({tag, " fill_data"}, fill_data, 32'h0);
        check({tag, " clr_dirty"}, 32'(clr_dirty), 32'h0);
        check({tag, " done"}, 32'(done), 32'h0);
        check({tag, " flushed"}, 32'(flushed), 32'h0);
    endtask

    // Stall test: WB0, WB1, RD0, RD1 of a dirty miss, tag 3 / victim tag 2, set 1.
    logic [31:0] st_addr [4] = '{32'h88, 32'h8C, 32'hC8, 32'hCC};
    logic [31:0] st_data [4] = '{32'hA0, 32'hA1, 32'h0, 32'h0};
    logic        st_wen  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

    // Flush test: cache model state
    logic [7:0]  dirty_mask;
    logic [31:0] wa [8];
    logic [31:0] wd [8];

    task automatic set_vic();
        vic_dirty = dirty_mask[fill_indx];
        vic_tag   = 26'h100 + 26'(fill_indx);
        vic_word0 = 32'hD000_0000 + {25'h0, fill_indx, 4'h0};
        vic_word1 = 32'hD000_0001 + {25'h0, fill_indx, 4'h0};
    endtask

    initial begin
        int nwr, nclr, cyc, exp_wr;

        // ---------------- reset state ----------------
        nRST = 1'b0;
        tick(); tick();
        chk_zero("reset");
        nRST = 1'b1;
        $display("reset: outputs all zero");

        // ---------------- clean miss ----------------
        req = 1'b1; req_tag = 26'hAB; req_indx = 3'd3; vic_dirty = 1'b0; dwait = 1'b0;
        tick();
        chk_bus("clean rd0", 1'b1, 1'b0, 32'h2AD8, 32'h0);
        check("clean rd0 done", 32'(done), 32'h0);
        dload = 32'h1111_0000;
        tick();
        chk_bus("clean rd1", 1'b1, 1'b0, 32'h2ADC, 32'h0);
        check("clean fill0 we", 32'(fill_we), 32'h1);
        check("clean fill0 off", 32'(fill_offset), 32'h0);
        check("clean fill0 data", fill_data, 32'h1111_0000);
        check("clean fill indx", 32'(fill_indx), 32'h3);
        check("clean fill tag", 32'(fill_tag), 32'hAB);
        check("clean rd1 done", 32'(done), 32'h0);
        dload = 32'h2222_1111;
        tick();
        check("clean done", 32'(done), 32'h1);
        check("clean clr_dirty", 32'(clr_dirty), 32'h1);
        check("clean fill1 we", 32'(fill_we), 32'h1);
        check("clean fill1 off", 32'(fill_offset), 32'h1);
        check("clean fill1 data", fill_data, 32'h2222_1111);
        check("clean done dREN", 32'(dREN), 32'h0);
        req = 1'b0;
        tick();
        check("clean after done", 32'(done), 32'h0);
        check("clean after fill_we", 32'(fill_we), 32'h0);
        check("clean after clr", 32'(clr_dirty), 32'h0);
        $display("clean miss tag=0x0000ab indx=3 serviced");

        // ---------------- dirty miss ----------------
        req = 1'b1; req_tag = 26'h5; req_indx = 3'd2;
        vic_dirty = 1'b1; vic_tag = 26'h1; vic_word0 = 32'hDEAD; vic_word1 = 32'hBEEF;
        tick();
        chk_bus("dirty wb0", 1'b0, 1'b1, 32'h50, 32'hDEAD);
        check("dirty wb0 done", 32'(done), 32'h0);
        tick();
        chk_bus("dirty wb1", 1'b0, 1'b1, 32'h54, 32'hBEEF);
        tick();
        chk_bus("dirty rd0", 1'b1, 1'b0, 32'h150, 32'h0);
        dload = 32'h33;
        tick();
        chk_bus("dirty rd1", 1'b1, 1'b0, 32'h154, 32'h0);
        check("dirty fill0 data", fill_data, 32'h33);
        check("dirty rd1 done", 32'(done), 32'h0);
        dload = 32'h44;
        tick();
        check("dirty done", 32'(done), 32'h1);
        check("dirty fill1 data", fill_data, 32'h44);
        check("dirty fill indx", 32'(fill_indx), 32'h2);
        check("dirty fill tag", 32'(fill_tag), 32'h5);
        req = 1'b0; vic_dirty = 1'b0;
        tick();
        $display("dirty miss tag=0x000005 indx=2 victim=0x000001 serviced");

        // ---------------- stalled dirty miss ----------------
        req = 1'b1; req_tag = 26'h3; req_indx = 3'd1;
        vic_dirty = 1'b1; vic_tag = 26'h2; vic_word0 = 32'hA0; vic_word1 = 32'hA1;
        dwait = 1'b1; dload = 32'h55;
        tick();
        for (int a = 0; a < 4; a++) begin
            if (a == 3) dload = 32'h66;
            for (int k = 0; k < 4; k++) begin
                chk_bus($sformatf("stall acc%0d cyc%0d", a, k), !st_wen[a], st_wen[a], st_addr[a], st_data[a]);
                check($sformatf("stall acc%0d cyc%0d done", a, k), 32'(done), 32'h0);
                tick();
            end
            chk_bus($sformatf("stall acc%0d last", a), !st_wen[a], st_wen[a], st_addr[a], st_data[a]);
            dwait = 1'b0;
            tick();
            dwait = 1'b1;
        end
        check("stall done", 32'(done), 32'h1);
        check("stall fill data", fill_data, 32'h66);
        req = 1'b0; vic_dirty = 1'b0; dwait = 1'b0;
        tick();
        $display("stalled miss tag=0x000003 indx=1 serviced");

        // ---------------- req and halt together ----------------
        req = 1'b1; req_tag = 26'h7; req_indx = 3'd5; vic_dirty = 1'b0; halt = 1'b1;
        tick(); tick(); tick();
        check("rh done", 32'(done), 32'h1);
        check("rh flushed early", 32'(flushed), 32'h0);
        req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("rh walk set%0d", k), 32'(fill_indx), 32'(k));
            check($sformatf("rh walk set%0d dWEN", k), 32'(dWEN), 32'h0);
            check($sformatf("rh walk set%0d flushed", k), 32'(flushed), 32'h0);
        end
        tick();
        check("rh fl_end flushed", 32'(flushed), 32'h0);
`ifdef HITCOUNT_EN
        chk_bus("rh hitcount", 1'b0, 1'b1, 32'h3100, 32'h1234_5678);
`endif
        tick();
        check("rh flushed", 32'(flushed), 32'h1);
        chk_bus("rh halted", 1'b0, 1'b0, 32'h0, 32'h0);
        req = 1'b1; vic_dirty = 1'b1;
        tick(); tick();
        chk_bus("halted ignores req", 1'b0, 1'b0, 32'h0, 32'h0);
        check("halted done", 32'(done), 32'h0);
        check("halted sticky", 32'(flushed), 32'h1);
        req = 1'b0; vic_dirty = 1'b0; halt = 1'b0;
        $display("req+halt: miss done, 8 clean sets walked, flushed");

        // ---------------- reset during RD1 ----------------
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        req = 1'b1; req_tag = 26'h9; req_indx = 3'd4;
        tick(); tick();
        check("rst rd1 reached", 32'(fill_we), 32'h1);
        nRST = 1'b0;
        tick();
        chk_zero("rst in rd1");
        nRST = 1'b1; req = 1'b0;
        tick();
        chk_zero("rst in rd1 after");
        $display("reset during rd1: aborted");

        // ---------------- flush with sets 1 and 6 dirty ----------------
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        dirty_mask = 8'b0100_0010;
        for (int i = 0; i < 8; i++) begin wa[i] = '0; wd[i] = '0; end
        nwr = 0; nclr = 0; cyc = 0;
        halt = 1'b1;
        set_vic();
        while (!flushed && cyc < 60) begin
            tick();
            cyc++;
            if (clr_dirty) begin
                nclr++;
                dirty_mask[fill_indx] = 1'b0;
            end
            if (dWEN && nwr < 8) begin
                wa[nwr] = daddr; wd[nwr] = dstore; nwr++;
            end
            set_vic();
        end
`ifdef HITCOUNT_EN
        exp_wr = 5;
        check("flush wr4 addr", wa[4], 32'h3100);
        check("flush wr4 data", wd[4], 32'h1234_5678);
`else
        exp_wr = 4;
`endif
        check("flush flushed", 32'(flushed), 32'h1);
        check("flush cycles", 32'(cyc), 32'd16);
        check("flush writes", 32'(nwr), 32'(exp_wr));
        check("flush clr pulses", 32'(nclr), 32'd2);
        check("flush wr0 addr", wa[0], 32'h4048);
        check("flush wr0 data", wd[0], 32'hD000_0010);
        check("flush wr1 addr", wa[1], 32'h404C);
        check("flush wr1 data", wd[1], 32'hD000_0011);
        check("flush wr2 addr", wa[2], 32'h41B0);
        check("flush wr2 data", wd[2], 32'hD000_0060);
        check("flush wr3 addr", wa[3], 32'h41B4);
        check("flush wr3 data", wd[3], 32'hD000_0061);
        halt = 1'b0;
        $display("flush sets 1,6 dirty: %0d writes, %0d clr pulses, %0d cycles", nwr, nclr, cyc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
